bus_arbiter: RTL and testbench

- Sequences the shared 16-bit processor bus register by arbitrating among the four bus gates: MARMUX, PC, ALU and MDR.
- Drives the bus register's bus_sel and ld_bus controls.
- Runs a req/gnt handshake with the requesters and a valid/taken handshake with the bus consumer.
- Sits between control/requester logic and the bus register; one transfer is in flight at a time.

---
 rtl/lc3_bus_pkg.sv | 25 ++
 rtl/rr_pick4.sv | 38 +++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 style processor bus arbiter.
// Gate selects, request bit positions and arbiter state encoding.
package lc3_bus_pkg;

    localparam logic [1:0] GATE_MARMUX = 2'd0;
    localparam logic [1:0] GATE_PC     = 2'd1;
    localparam logic [1:0] GATE_ALU    = 2'd2;
    localparam logic [1:0] GATE_MDR    = 2'd3;

    localparam int REQ_MARMUX = 0;
    localparam int REQ_PC     = 1;
    localparam int REQ_ALU    = 2;
    localparam int REQ_MDR    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_VALID = 2'd2
    } arb_state_t;

    function automatic logic [3:0] gate_onehot(input logic [1:0] g);
        gate_onehot = 4'b0001 << g;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: fixed priority (index 0 first) or
// round-robin starting just after the last-grant pointer.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] pointer,
    input  logic       mode,
    output logic [1:0] winner,
    output logic       any
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        any    = |req;
        if (mode) begin
            // i=4 wraps onto the pointer itself, so it is searched last
            for (int i = 1; i <= 4; i++) begin
                idx = pointer + 2'(i);
                if (!found && req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!found && req[i]) begin
                    winner = 2'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Sequences the shared bus register among MARMUX, PC, ALU and MDR:
// IDLE -> LOAD (one cycle, bus register loads) -> VALID until taken.
module bus_arbiter
    import lc3_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4,
    parameter int ARB_MODE       = 1
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic [3:0] req,
    input  logic       bus_taken,
    output logic [1:0] bus_sel,
    output logic       ld_bus,
    output logic [3:0] gnt,
    output logic       bus_valid,
    output logic [1:0] bus_owner,
    output logic       timeout,
    output logic       busy
);

    localparam logic           MODE  = (ARB_MODE != 0);
    localparam logic           TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       win;
    logic             any;

    assign cnt_inc = cnt + CNT_W'(1);

    rr_pick4 u_pick (
        .req     (req),
        .pointer (ptr),
        .mode    (MODE),
        .winner  (win),
        .any     (any)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= ST_IDLE;
            ptr       <= 2'd3;
            cnt       <= '0;
            bus_sel   <= GATE_MARMUX;
            ld_bus    <= 1'b0;
            gnt       <= 4'b0000;
            bus_valid <= 1'b0;
            bus_owner <= 2'd0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ld_bus  <= 1'b0;
            gnt     <= 4'b0000;
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        state     <= ST_LOAD;
                        bus_owner <= win;
                        ptr       <= win;
                        bus_sel   <= win;
                        ld_bus    <= 1'b1;
                        gnt       <= gate_onehot(win);
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_VALID;
                    bus_valid <= 1'b1;
                end
                ST_VALID: begin
                    if (bus_taken) begin
                        cnt <= '0;
                        if (any) begin
                            state     <= ST_LOAD;
                            bus_owner <= win;
                            ptr       <= win;
                            bus_sel   <= win;
                            ld_bus    <= 1'b1;
                            gnt       <= gate_onehot(win);
                            bus_valid <= 1'b0;
                        end else begin
                            state     <= ST_IDLE;
                            bus_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else if (TO_EN && cnt_inc == TO_VAL) begin
                        // abandoned transfer: consumer never sampled
                        timeout   <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        bus_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one round-robin and one
// fixed-priority instance share the same stimulus.
module tb_bus_arbiter;

    logic       clk;
    logic       reset_;
    logic [3:0] req;
    logic       bus_taken;

    logic [1:0] rr_sel, rr_owner, fp_sel, fp_owner;
    logic [3:0] rr_gnt, fp_gnt;
    logic       rr_ld, rr_valid, rr_to, rr_busy;
    logic       fp_ld, fp_valid, fp_to, fp_busy;

    int n_cmp;
    int n_bad;

    bus_arbiter #(
        .TIMEOUT_CYCLES (3),
        .CNT_W          (4),
        .ARB_MODE       (1)
    ) u_rr (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req),
        .bus_taken (bus_taken),
        .bus_sel   (rr_sel),
        .ld_bus    (rr_ld),
        .gnt       (rr_gnt),
        .bus_valid (rr_valid),
        .bus_owner (rr_owner),
        .timeout   (rr_to),
        .busy      (rr_busy)
    );

    bus_arbiter #(
        .TIMEOUT_CYCLES (3),
        .CNT_W          (4),
        .ARB_MODE       (0)
    ) u_fp (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req),
        .bus_taken (bus_taken),
        .bus_sel   (fp_sel),
        .ld_bus    (fp_ld),
        .gnt       (fp_gnt),
        .bus_valid (fp_valid),
        .bus_owner (fp_owner),
        .timeout   (fp_to),
        .busy      (fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = 4'b0000;
        bus_taken = 1'b0;
        reset_    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    logic [3:0] exp_rr2 [5];
    logic [3:0] exp_rr3 [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_rr2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_rr3 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        // reset state
        do_reset();
        check("rst_gnt", rr_gnt, 4'b0000);
        check("rst_ld", rr_ld, 1'b0);
        check("rst_valid", rr_valid, 1'b0);
        check("rst_busy", rr_busy, 1'b0);
        check("rst_sel", rr_sel, 2'd0);
        check("rst_owner", rr_owner, 2'd0);
        check("rst_to", rr_to, 1'b0);

        // single ALU transfer
        req = 4'b0100;
        step();
        check("t1_gnt", rr_gnt, 4'b0100);
        check("t1_ld", rr_ld, 1'b1);
        check("t1_sel", rr_sel, 2'd2);
        check("t1_busy", rr_busy, 1'b1);
        check("t1_fp_gnt", fp_gnt, 4'b0100);
        req = 4'b0000;
        bus_taken = 1'b1;
        step();
        check("t1_valid", rr_valid, 1'b1);
        check("t1_owner", rr_owner, 2'd2);
        check("t1_ld_off", rr_ld, 1'b0);
        check("t1_gnt_off", rr_gnt, 4'b0000);
        step();
        check("t1_idle_busy", rr_busy, 1'b0);
        check("t1_idle_valid", rr_valid, 1'b0);

        // round-robin rotation, back-to-back
        do_reset();
        req = 4'b1111;
        bus_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_rr_gnt", rr_gnt, exp_rr2[i]);
            check("t2_rr_ld", rr_ld, 1'b1);
            check("t2_fp_gnt", fp_gnt, 4'b0001);
            step();
            check("t2_rr_valid", rr_valid, 1'b1);
            check("t2_rr_busy", rr_busy, 1'b1);
        end
        req = 4'b0000;
        step();
        check("t2_end_busy", rr_busy, 1'b0);

        // fixed priority never reaches MDR while PC is held
        do_reset();
        req = 4'b1010;
        bus_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_fp_gnt", fp_gnt, 4'b0010);
            check("t3_rr_gnt", rr_gnt, exp_rr3[i]);
            step();
            check("t3_fp_owner", fp_owner, 2'd1);
        end
        req = 4'b0000;
        step();

        // timeout after three untaken VALID cycles
        do_reset();
        req = 4'b1000;
        step();
        check("t4_gnt", rr_gnt, 4'b1000);
        check("t4_sel", rr_sel, 2'd3);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_valid", rr_valid, 1'b1);
            check("t4_no_to", rr_to, 1'b0);
        end
        step();
        check("t4_to", rr_to, 1'b1);
        check("t4_fp_to", fp_to, 1'b1);
        check("t4_valid_off", rr_valid, 1'b0);
        check("t4_busy_off", rr_busy, 1'b0);
        step();
        check("t4_to_pulse", rr_to, 1'b0);

        // taken in the expiring cycle wins
        do_reset();
        req = 4'b1000;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        check("t5_v3_valid", rr_valid, 1'b1);
        bus_taken = 1'b1;
        step();
        check("t5_no_to", rr_to, 1'b0);
        check("t5_idle", rr_busy, 1'b0);
        check("t5_valid_off", rr_valid, 1'b0);
        bus_taken = 1'b0;
        step();
        check("t5_still_no_to", rr_to, 1'b0);

        // asynchronous reset during LOAD
        do_reset();
        req = 4'b0100;
        step();
        check("t6_ld", rr_ld, 1'b1);
        #2;
        reset_ = 1'b0;
        #1;
        check("t6_ld_async", rr_ld, 1'b0);
        check("t6_gnt_async", rr_gnt, 4'b0000);
        check("t6_busy_async", rr_busy, 1'b0);
        step();
        check("t6_gnt_held", rr_gnt, 4'b0000);
        check("t6_to_held", rr_to, 1'b0);
        reset_ = 1'b1;
        req = 4'b0001;
        step();
        check("t6_gnt", rr_gnt, 4'b0001);
        check("t6_owner", rr_owner, 2'd0);
        check("t6_sel", rr_sel, 2'd0);
        req = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
